// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART command-frame parser.
package uart_frame_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_LEN,
        ST_DATA,
        ST_SUM
    } state_t;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_SUM  = 2'd1;
    localparam logic [1:0] ERR_LEN  = 2'd2;
    localparam logic [1:0] ERR_TMO  = 2'd3;

    localparam logic [7:0] SOF_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_frame_timer.sv
// Inter-byte gap counter: cleared by each byte strobe, held at zero while disabled.
module uart_frame_timer #(
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr || !i_en) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // Fires on the cycle whose edge brings the count to TIMEOUT_CYC-1, so the
    // error pulse lands exactly TIMEOUT_CYC cycles after the last strobe.
    // A strobe in the same cycle suppresses it.
    assign o_expire = i_en & ~i_clr & (r_cnt == CW'(TIMEOUT_CYC - 2));

endmodule

// File: rtl/uart_frame_parser.sv
// Assembles SOF/CMD/LEN/payload/checksum frames from UART bytes and holds the last good one.
module uart_frame_parser
    import uart_frame_pkg::*;
#(
    parameter int          CLK_FREQ    = 100000000,
    parameter int          MAX_LEN     = 16,
    parameter int          TIMEOUT_CYC = CLK_FREQ / 1000,
    parameter logic [7:0]  SOF         = SOF_DEFAULT,
    localparam int         LW          = $clog2(MAX_LEN + 1),
    localparam int         IW          = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          RXFLAG,
    input  logic [7:0]    RDR,
    output logic [7:0]    CMD,
    output logic [LW-1:0] LEN,
    input  logic [IW-1:0] PAYLOAD_IDX,
    output logic [7:0]    PAYLOAD_DATA,
    output logic          FRAME_VALID,
    output logic          FRAME_ERR,
    output logic [1:0]    ERR_CODE,
    output logic          BUSY
);

    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    state_t        r_state, w_state_nxt;
    logic          r_rxflag_q;
    logic          w_stb, w_expire, w_last;
    logic          w_accept, w_fail;
    logic [1:0]    w_fail_code;

    logic [7:0]    r_cmd_w, r_sum;
    logic [LW-1:0] r_len_w;
    logic [IW-1:0] r_idx;
    logic [7:0]    r_work [MAX_LEN];

    logic [7:0]    r_cmd;
    logic [LW-1:0] r_len;
    logic [7:0]    r_hold [MAX_LEN];
    logic [1:0]    r_err_code;
    logic          r_valid, r_err;

    assign w_stb  = RXFLAG & ~r_rxflag_q;
    assign w_last = (LW'(r_idx) + LW'(1)) == r_len_w;

    uart_frame_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .i_clk    (CLK),
        .i_rst_n  (RST_N),
        .i_clr    (w_stb),
        .i_en     (r_state != ST_IDLE),
        .o_expire (w_expire)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_fail      = 1'b0;
        w_fail_code = ERR_NONE;
        if (w_stb) begin
            case (r_state)
                ST_IDLE: if (RDR == SOF) w_state_nxt = ST_CMD;
                ST_CMD:  w_state_nxt = ST_LEN;
                ST_LEN: begin
                    if (RDR > MAX_LEN_B) begin
                        w_fail      = 1'b1;
                        w_fail_code = ERR_LEN;
                        w_state_nxt = ST_IDLE;
                    end else if (RDR == 8'h00) begin
                        w_state_nxt = ST_SUM;
                    end else begin
                        w_state_nxt = ST_DATA;
                    end
                end
                ST_DATA: if (w_last) w_state_nxt = ST_SUM;
                ST_SUM: begin
                    if (RDR == r_sum) begin
                        w_accept = 1'b1;
                    end else begin
                        w_fail      = 1'b1;
                        w_fail_code = ERR_SUM;
                    end
                    w_state_nxt = ST_IDLE;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end else if (w_expire) begin
            w_fail      = 1'b1;
            w_fail_code = ERR_TMO;
            w_state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state    <= ST_IDLE;
            r_rxflag_q <= 1'b0;
            r_valid    <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= ERR_NONE;
            r_cmd      <= '0;
            r_len      <= '0;
            for (int i = 0; i < MAX_LEN; i++) r_hold[i] <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_rxflag_q <= RXFLAG;
            r_valid    <= w_accept;
            r_err      <= w_fail;
            if (w_fail) r_err_code <= w_fail_code;
            if (w_accept) begin
                r_cmd  <= r_cmd_w;
                r_len  <= r_len_w;
                r_hold <= r_work;
            end
        end
    end

    // Working registers carry no reset: the FSM always rewrites them before use.
    always_ff @(posedge CLK) begin
        if (w_stb) begin
            case (r_state)
                ST_CMD: begin
                    r_cmd_w <= RDR;
                    r_sum   <= RDR;
                end
                ST_LEN: begin
                    r_len_w <= RDR[LW-1:0];
                    r_sum   <= r_sum + RDR;
                    r_idx   <= '0;
                end
                ST_DATA: begin
                    r_work[r_idx] <= RDR;
                    r_sum         <= r_sum + RDR;
                    r_idx         <= r_idx + IW'(1);
                end
                default: ;
            endcase
        end
    end

    assign CMD          = r_cmd;
    assign LEN          = r_len;
    assign PAYLOAD_DATA = (LW'(PAYLOAD_IDX) < r_len) ? r_hold[PAYLOAD_IDX] : 8'h00;
    assign FRAME_VALID  = r_valid;
    assign FRAME_ERR    = r_err;
    assign ERR_CODE     = r_err_code;
    assign BUSY         = (r_state != ST_IDLE);

endmodule

// File: doc/uart_frame_parser.md
# uart_frame_parser

Byte-level frame parser sitting directly downstream of the UART receiver. Consumes the receiver's byte-ready flag and data byte, assembles fixed-format command frames (SOF, command, length, payload, checksum), validates them, and presents the last good frame in hold registers for the application logic. Corrupt, oversized or stalled frames are dropped and reported via an error pulse and code.

## Interface

Parameters:
- CLK_FREQ, 100000000: system clock frequency in Hz.
- MAX_LEN, 16: maximum payload bytes. Range 1..255.
- TIMEOUT_CYC, CLK_FREQ/1000: inter-byte gap limit in clocks (1 ms).
- SOF, 8'hA5: start-of-frame byte.

Ports:
- CLK, input, 1: system clock; all logic on the rising edge.
- RST_N, input, 1: asynchronous active-low reset.
- RXFLAG, input, 1: byte-ready level from the UART receiver. The rising edge marks a new byte. It may stay high for many cycles.
- RDR, input, 8: received byte. Stable whenever RXFLAG is high.
- CMD, output, 8: command of the last valid frame.
- LEN, output, $clog2(MAX_LEN+1): payload length of the last valid frame.
- PAYLOAD_IDX, input, $clog2(MAX_LEN): payload read index.
- PAYLOAD_DATA, output, 8: combinational read of the held payload at PAYLOAD_IDX. Reads 0 for PAYLOAD_IDX ≥ LEN.
- FRAME_VALID, output, 1: one-cycle pulse. CMD, LEN and payload were updated.
- FRAME_ERR, output, 1: one-cycle pulse. The frame was dropped.
- ERR_CODE, output, 2: cause of the last error. 0 none, 1 checksum, 2 length, 3 timeout. Holds until the next error.
- BUSY, output, 1: high whenever the state is not IDLE.

## Operation

- Byte strobe: `stb = RXFLAG & ~rxflag_q`, where `rxflag_q` is RXFLAG registered. RDR is sampled in the strobe cycle.
- States and transitions on `stb`:
  - IDLE: byte == SOF goes to CMD. Any other byte is dropped silently.
  - CMD: store the byte in `cmd_w` and set `sum = byte`; go to LEN.
  - LEN:
    - byte > MAX_LEN: error code 2, go to IDLE.
    - byte == 0: go to SUM.
    - otherwise: store `len_w`, clear `idx`, go to DATA.
    - In all non-error cases, `sum += byte`.
  - DATA: `work[idx] = byte`, `sum += byte`, `idx++`. Go to SUM when `idx == len_w-1`.
  - SUM:
    - byte == sum (mod 256): copy `cmd_w`, `len_w` and `work[]` into the hold registers, pulse FRAME_VALID.
    - otherwise: error code 1.
    - Go to IDLE in both cases.
- Checksum is an 8-bit wrapping sum of CMD, LEN and all payload bytes. The SOF byte is excluded.
- Timeout:
  - The counter clears on every `stb` and counts while the state is not IDLE.
  - When it reaches TIMEOUT_CYC-1: error code 3, go to IDLE.
  - It is held at 0 in IDLE.
- Simultaneous `stb` and timeout in the same cycle: the strobe wins. The byte is processed and the counter cleared.
- Hold registers change only on FRAME_VALID. Errors leave CMD, LEN and the payload untouched.
- An SOF byte seen mid-frame is treated as data. There is no resynchronisation except via error or timeout.

## Timing

- Reset values:
  - CMD, LEN, all payload, ERR_CODE = 0.
  - FRAME_VALID, FRAME_ERR, BUSY = 0.
  - State IDLE, `rxflag_q` = 0.
- RXFLAG rises in cycle T, so `stb` is high in T. The FSM updates at the end of T.
- FRAME_VALID / FRAME_ERR pulse in T+1, with the hold registers and ERR_CODE already updated in T+1.
- Timeout error pulses in the cycle after the counter reaches TIMEOUT_CYC-1.
- BUSY rises the cycle after the SOF strobe. It falls in the same cycle as the FRAME_VALID / FRAME_ERR pulse.
- PAYLOAD_DATA has zero latency from PAYLOAD_IDX.
- Reset asserted mid-frame: the partial frame is discarded immediately and all outputs return to reset values. No error pulse is generated.

## Structure

- Package `uart_frame_pkg`:
  - state enum: IDLE, CMD, LEN, DATA, SUM;
  - error-code constants: ERR_NONE, ERR_SUM, ERR_LEN, ERR_TMO;
  - default SOF.
- Sub-module `uart_frame_timer`: the inter-byte timeout counter.
  - Inputs: clear, enable.
  - Output: an expiry pulse.
  - Parameter: TIMEOUT_CYC.
- Working and hold payload arrays: flops, MAX_LEN × 8 each.

## Test plan

- A5 01 02 11 22 36 → one FRAME_VALID pulse; CMD=01, LEN=2, payload[0]=11, payload[1]=22, payload[2] reads 00.
- Same frame with checksum 37 → FRAME_ERR, ERR_CODE=1; CMD/LEN/payload keep their previous values; BUSY low afterwards.
- A5 7F 00 7F → FRAME_VALID, CMD=7F, LEN=0. Hold RXFLAG high for 50 cycles per byte → still exactly one byte per edge.
- A5 01 11 (MAX_LEN=16) → FRAME_ERR and ERR_CODE=2 after the length byte. The following bytes 00 FF are ignored; the next A5 03 01 44 48 → valid, CMD=03, LEN=1, payload[0]=44.
- Bytes 00 FF 5A, then A5 01 followed by a gap > TIMEOUT_CYC → FRAME_ERR with ERR_CODE=3 exactly TIMEOUT_CYC cycles after the 01 strobe. Also deliver a strobe on the expiry cycle → byte processed, no error.
- Assert RST_N low during the DATA state → all outputs return to 0 asynchronously. After release, a full valid frame is accepted normally.
